// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared types and defaults for the multi-cycle data memory
package data_memory_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam int DEF_ADDR_WIDTH = 6;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_LATENCY    = 5;

    // Wide enough to hold LATENCY itself, so LATENCY-1 always fits.
    function automatic int counter_width(input int latency);
        return $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/mem_latency_timer.sv
// rtl/mem_latency_timer.sv - loadable down-counter with zero flag for memory access timing
module mem_latency_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/param_data_memory.sv
// rtl/param_data_memory.sv - parametrised multi-cycle block memory with busywait handshake
module param_data_memory
    import data_memory_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int LATENCY        = DEF_LATENCY,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] writedata,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic                  busywait,
    output logic                  error
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CNT_W = counter_width(LATENCY);
    localparam logic [CNT_W-1:0] LOAD_VALUE = CNT_W'(LATENCY - 1);

    mem_state_t r_state;
    mem_state_t w_next_state;

    logic                  r_op_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic             w_load;
    logic             w_commit;
    logic             w_zero;
    logic             w_count_en;
    logic [CNT_W-1:0] w_count;

    assign w_count_en = (r_state == BUSY);

    mem_latency_timer #(
        .WIDTH(CNT_W)
    ) u_timer (
        .clock        (clock),
        .reset        (reset),
        .i_load       (w_load),
        .i_load_value (LOAD_VALUE),
        .i_enable     (w_count_en),
        .o_count      (w_count),
        .o_zero       (w_zero)
    );

    always_comb begin
        w_next_state = r_state;
        busywait     = 1'b0;
        w_load       = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                // Simultaneous read and write is rejected without stalling the requester.
                busywait = read ^ write;
                if (read ^ write) begin
                    w_load       = 1'b1;
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                busywait = 1'b1;
                if (w_zero) begin
                    w_commit     = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            readdata   <= '0;
            error      <= 1'b0;
            r_op_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_state <= w_next_state;
            error   <= (r_state == IDLE) && read && write;
            if (w_load) begin
                r_op_write <= write;
                r_addr     <= address;
                r_wdata    <= writedata;
            end
            if (w_commit && !r_op_write) begin
                readdata <= r_mem[r_addr];
            end
        end
    end

    generate
        if (CLEAR_ON_RESET) begin : g_clear_mem
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_mem[i] <= '0;
                    end
                end else if (w_commit && r_op_write) begin
                    r_mem[r_addr] <= r_wdata;
                end
            end
        end else begin : g_keep_mem
            always_ff @(posedge clock) begin
                if (w_commit && r_op_write && !reset) begin
                    r_mem[r_addr] <= r_wdata;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_param_data_memory.sv
// tb/tb_param_data_memory.sv - directed self-checking bench for param_data_memory
module tb_param_data_memory;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        read = 1'b0, write = 1'b0;
    logic [5:0]  address = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        busywait, error;

    logic        read1 = 1'b0, write1 = 1'b0;
    logic [5:0]  address1 = '0;
    logic [31:0] writedata1 = '0;
    logic [31:0] readdata1;
    logic        busywait1, error1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    param_data_memory #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .LATENCY(5), .CLEAR_ON_RESET(1'b1)) dut (
        .clock(clock), .reset(reset), .read(read), .write(write), .address(address),
        .writedata(writedata), .readdata(readdata), .busywait(busywait), .error(error)
    );

    param_data_memory #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .LATENCY(1), .CLEAR_ON_RESET(1'b1)) dut1 (
        .clock(clock), .reset(reset), .read(read1), .write(write1), .address(address1),
        .writedata(writedata1), .readdata(readdata1), .busywait(busywait1), .error(error1)
    );

    // Starts at a negedge in IDLE; returns at the negedge in DONE.
    task automatic access(input logic wr, input logic [5:0] a, input logic [31:0] d,
                          input logic hold, input string name);
        int hi;
        read = !wr; write = wr; address = a; writedata = d;
        #1;
        n_tests++;
        if (busywait !== 1'b1) begin
            n_fail++; $display("FAIL %s_req_busy: got %b expected 1", name, busywait);
        end
        hi = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (busywait === 1'b1) hi++;
            else break;
        end
        n_tests++;
        if (hi !== 6) begin
            n_fail++; $display("FAIL %s_busy_cycles: got %0d expected 6", name, hi);
        end
        if (!hold) begin
            read = 1'b0; write = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        n_tests++;
        if (readdata !== 32'h0 || error !== 1'b0 || busywait !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: got rd=%h err=%b bw=%b expected 0/0/0", readdata, error, busywait);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_read_after_reset();
        access(1'b0, 6'h03, 32'h0, 1'b0, "rd03");
        n_tests++;
        if (readdata !== 32'h0) begin
            n_fail++; $display("FAIL rd03_data: got %h expected 00000000", readdata);
        end
        n_tests++;
        if (busywait !== 1'b0) begin
            n_fail++; $display("FAIL rd03_done_busy: got %b expected 0", busywait);
        end
        @(negedge clock);
        n_tests++;
        if (busywait !== 1'b0) begin
            n_fail++; $display("FAIL rd03_idle_busy: got %b expected 0", busywait);
        end
    endtask

    task automatic test_write_read();
        access(1'b1, 6'h2A, 32'hDEADBEEF, 1'b0, "wr2a");
        n_tests++;
        if (readdata !== 32'h0) begin
            n_fail++; $display("FAIL wr2a_rd_unchanged: got %h expected 00000000", readdata);
        end
        @(negedge clock);
        access(1'b0, 6'h2A, 32'h0, 1'b0, "rd2a");
        n_tests++;
        if (readdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL rd2a_data: got %h expected deadbeef", readdata);
        end
        @(negedge clock);
    endtask

    task automatic test_abort_reset();
        read = 1'b0; write = 1'b1; address = 6'h3F; writedata = 32'h12345678;
        repeat (3) @(negedge clock);
        reset = 1'b1; write = 1'b0;
        #1;
        n_tests++;
        if (busywait !== 1'b0 || readdata !== 32'h0) begin
            n_fail++; $display("FAIL abort_outputs: got bw=%b rd=%h expected 0/00000000", busywait, readdata);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        access(1'b0, 6'h3F, 32'h0, 1'b0, "rd3f");
        n_tests++;
        if (readdata !== 32'h0) begin
            n_fail++; $display("FAIL rd3f_data: got %h expected 00000000", readdata);
        end
        @(negedge clock);
        access(1'b0, 6'h2A, 32'h0, 1'b0, "rd2a_clr");
        n_tests++;
        if (readdata !== 32'h0) begin
            n_fail++; $display("FAIL rd2a_cleared: got %h expected 00000000", readdata);
        end
        @(negedge clock);
    endtask

    task automatic test_illegal();
        access(1'b1, 6'h10, 32'hCAFEF00D, 1'b0, "wr10");
        @(negedge clock);
        read = 1'b1; write = 1'b1; address = 6'h10; writedata = 32'h11111111;
        #1;
        n_tests++;
        if (busywait !== 1'b0 || error !== 1'b0) begin
            n_fail++; $display("FAIL ill_req: got bw=%b err=%b expected 0/0", busywait, error);
        end
        @(negedge clock);
        read = 1'b0; write = 1'b0;
        #1;
        n_tests++;
        if (error !== 1'b1 || busywait !== 1'b0) begin
            n_fail++; $display("FAIL ill_pulse: got err=%b bw=%b expected 1/0", error, busywait);
        end
        @(negedge clock);
        n_tests++;
        if (error !== 1'b0) begin
            n_fail++; $display("FAIL ill_one_cycle: got %b expected 0", error);
        end
        access(1'b0, 6'h10, 32'h0, 1'b0, "rd10");
        n_tests++;
        if (readdata !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL rd10_data: got %h expected cafef00d", readdata);
        end
        @(negedge clock);
    endtask

    task automatic test_held_read();
        access(1'b0, 6'h2A, 32'h0, 1'b1, "hold1");
        n_tests++;
        if (busywait !== 1'b0) begin
            n_fail++; $display("FAIL hold_done_busy: got %b expected 0", busywait);
        end
        @(negedge clock);
        access(1'b0, 6'h10, 32'h0, 1'b0, "hold2");
        n_tests++;
        if (readdata !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL hold2_data: got %h expected cafef00d", readdata);
        end
        @(negedge clock);
    endtask

    task automatic test_latency1();
        int hi;
        for (int k = 0; k < 2; k++) begin
            write1 = (k == 0); read1 = (k == 1); address1 = 6'h00; writedata1 = 32'hA5A5A5A5;
            hi = 0;
            #1;
            if (busywait1 === 1'b1) hi++;
            for (int i = 0; i < 20; i++) begin
                @(negedge clock);
                if (busywait1 === 1'b1) hi++;
                else break;
            end
            n_tests++;
            if (hi !== 2) begin
                n_fail++; $display("FAIL lat1_busy_cycles_%0d: got %0d expected 2", k, hi);
            end
            read1 = 1'b0; write1 = 1'b0;
            @(negedge clock);
        end
        n_tests++;
        if (readdata1 !== 32'hA5A5A5A5) begin
            n_fail++; $display("FAIL lat1_data: got %h expected a5a5a5a5", readdata1);
        end
    endtask

    initial begin
        test_reset();
        test_read_after_reset();
        test_write_read();
        test_abort_reset();
        test_illegal();
        test_held_read();
        test_latency1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/param_data_memory.md
Name: param_data_memory

Overview:
- Parametrised multi-cycle data memory that serves block-wide (cache-line) reads and writes to the L1 data cache controller.
- Word width, depth and access latency are configurable.
- Busywait handshake is compatible with the existing CPU/cache stall logic.
- Adds a deterministic latency counter, an explicit completion state, and illegal-request detection.

Parameters:
ADDR_WIDTH, 6, block-address width; depth = 2**ADDR_WIDTH entries
DATA_WIDTH, 32, bits per entry (one cache block, multiple of 8)
LATENCY, 5, clock edges from request capture to access completion; legal range 1..255
CLEAR_ON_RESET, 1, 1 = reset zeroes all memory entries; 0 = contents retained

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears state and outputs
read  input  1  read request, held by requester until busywait falls
write  input  1  write request, held by requester until busywait falls
address  input  ADDR_WIDTH  block address
writedata  input  DATA_WIDTH  write data
readdata  output  DATA_WIDTH  read result, registered
busywait  output  1  stall request to requester
error  output  1  one-cycle registered pulse on illegal request (read and write together)

Behaviour:
- Reset (async, active-high; clock clock):
  - state=IDLE, counter=0, readdata=0, error=0.
  - busywait follows the IDLE rule below, so it is 0 while read=write=0.
  - If CLEAR_ON_RESET=1, all entries are 0.
  - Reset mid-access aborts the access: no write is committed and readdata is 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - busywait = read XOR write (combinational, same cycle as the request).
  - Posedge with read XOR write: latch op, address and writedata into internal regs; counter=LATENCY-1; go BUSY.
  - Posedge with read AND write: no access, error=1 for the next cycle only; stay IDLE. busywait=0 so the requester is not deadlocked.
- BUSY:
  - busywait=1.
  - Input changes are ignored; latched copies are used.
  - Each posedge with counter>0: counter decrements.
  - Posedge with counter==0:
    - Read: readdata <= mem[latched address].
    - Write: mem[latched address] <= latched writedata; readdata unchanged.
    - Go DONE.
- DONE:
  - busywait=0 for exactly one cycle.
  - Requests are not sampled, so a still-held request does not retrigger.
  - Next posedge: go IDLE.
- Latency:
  - Request is captured at edge E and committed at edge E+LATENCY.
  - busywait is high from the request cycle through the cycle ending at E+LATENCY, then low in DONE.
  - Back-to-back accesses: minimum spacing LATENCY+2 edges.
- readdata holds its last read value until the next read completes or reset.
- Write-then-read of the same address returns the written data. No bypass is needed because accesses are serialised.
- Address range is full 2**ADDR_WIDTH, with no wrap logic.
- LATENCY=1 is legal: BUSY lasts one cycle.

Decomposition:
- Package data_memory_pkg holds:
  - state enum {IDLE, BUSY, DONE}, 2-bit encoding
  - default parameter constants (DEF_ADDR_WIDTH=6, DEF_DATA_WIDTH=32, DEF_LATENCY=5)
  - counter width derived from LATENCY as $clog2(LATENCY+1)
- One natural sub-module, mem_latency_timer:
  - loadable down-counter with a load input and a zero flag
  - instantiated once
  - also reusable by the future instruction memory
- The storage array stays in the top module.

Test Plan (ADDR_WIDTH=6, DATA_WIDTH=32, LATENCY=5):
- Reset, then read addr 0x03 -> busywait rises in the same cycle, stays high 5 edges; readdata=0x00000000 in DONE; busywait=0 for one cycle.
- Write 0xDEADBEEF to 0x2A, then read 0x2A -> readdata=0xDEADBEEF after the 5th edge; each access shows 6 busywait-high cycles.
- Assert read and write together at 0x10 -> no state change, busywait=0, error=1 for exactly one cycle; mem[0x10] unchanged.
- Write 0x12345678 to 0x3F, assert reset at edge 3 of BUSY -> state IDLE, busywait=0, readdata=0. Subsequent read of 0x3F returns 0 (CLEAR_ON_RESET=1), or its prior contents (CLEAR_ON_RESET=0).
- Hold read high across DONE -> no second access is started; busywait stays 0 in DONE, then rises in IDLE, starting a fresh 5-edge access.
- LATENCY=1 rebuild: write 0xA5A5A5A5 to 0x00, read it back -> busywait high for 2 cycles per access; readdata=0xA5A5A5A5.
